// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues one outstanding request
// at a time to instruction memory, and buffers {instr, pc+4} for the IF/ID register.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o
);

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW      = PW + 1;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, occ_next;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pcp4_mem  [DEPTH];
  logic          push, pop, space;

  assign valid_o    = (count_q != '0);
  assign instr_o    = valid_o ? instr_mem[rd_ptr_q] : '0;
  assign pc_plus4_o = valid_o ? pcp4_mem[rd_ptr_q]  : '0;
  assign mem_addr_o = addr_q;

  assign pop = valid_o & ~stall_i & ~redirect_i;

  // Occupancy after this edge decides whether another request may be issued.
  assign occ_next = count_q + CW'(push) - CW'(pop);
  assign space    = (occ_next < CW'(DEPTH));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, next fetch PC and next request address
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
        end else if (space) begin
          addr_d  = fetch_pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack_i) begin
          if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            state_d    = IDLE;
          end else begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            if (space) begin
              addr_d = fetch_pc_q + PC_STEP;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (redirect_i) begin
          // Request stays on the bus until memory answers; its data is dropped.
          fetch_pc_d = redirect_pc_i;
          state_d    = DROP;
        end
      end
      DROP: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
        end
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    mem_req_o = 1'b0;
    push      = 1'b0;
    case (state_q)
      WAIT: begin
        mem_req_o = 1'b1;
        push      = mem_ack_i & ~redirect_i;
      end
      DROP: begin
        mem_req_o = 1'b1;
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
  end

  // Fetch PC, request address and FIFO bookkeeping; redirect flushes the queue
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      if (redirect_i) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        count_q  <= occ_next;
        rd_ptr_q <= rd_ptr_q + PW'(pop);
        wr_ptr_q <= wr_ptr_q + PW'(push);
      end
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= mem_data_i;
      pcp4_mem[wr_ptr_q]  <= addr_q + PC_STEP;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a configurable-latency instruction memory
// model that returns 0x2000_0000 | addr.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc_plus4;

  int errors = 0;
  int checks = 0;
  int lat = 0;
  int wait_cnt;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_ack_i     (mem_ack),
    .mem_data_i    (mem_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .stall_i       (stall),
    .valid_o       (valid),
    .instr_o       (instr),
    .pc_plus4_o    (pc_plus4)
  );

  always #5 clk = ~clk;

  // Memory model: ack after `lat` wait cycles of an active request
  assign mem_ack  = mem_req && (wait_cnt == lat);
  assign mem_data = 32'h2000_0000 | mem_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (!mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    stall = 1'b0;
    lat = l;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lat = 0;
    @(posedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", mem_addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", instr); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 00000000", pc_plus4); end
  endtask

  task automatic test_zero_wait();
    do_reset(0);
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL zw_first_req: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL zw_first_addr: got %h want 00000000", mem_addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL zw_first_valid: got %b want 0", valid); end
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d]: got %b want 1", k, valid); end
      checks++; if (instr !== 32'h2000_0000 + 32'(4 * k)) begin errors++; $display("FAIL zw_instr[%0d]: got %h want %h", k, instr, 32'h2000_0000 + 32'(4 * k)); end
      checks++; if (pc_plus4 !== 32'(4 * k + 4)) begin errors++; $display("FAIL zw_pc4[%0d]: got %h want %h", k, pc_plus4, 32'(4 * k + 4)); end
    end
  endtask

  task automatic test_stall();
    do_reset(0);
    stall = 1'b1;
    repeat (10) step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b want 0", mem_req); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", valid); end
    checks++; if (mem_addr !== 32'h0C) begin errors++; $display("FAIL stall_last_addr: got %h want 0000000c", mem_addr); end
    stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b want 1", k, valid); end
      checks++; if (instr !== 32'h2000_0000 + 32'(4 * k)) begin errors++; $display("FAIL drain_instr[%0d]: got %h want %h", k, instr, 32'h2000_0000 + 32'(4 * k)); end
      checks++; if (pc_plus4 !== 32'(4 * k + 4)) begin errors++; $display("FAIL drain_pc4[%0d]: got %h want %h", k, pc_plus4, 32'(4 * k + 4)); end
      if (k == 1) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL resume_addr: got req=%b addr=%h want req=1 addr=00000010", mem_req, mem_addr); end
      end
      step();
    end
  endtask

  task automatic test_latency();
    logic exp_valid;
    do_reset(3);
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_valid = (k > 1) && ((k % 4) == 1);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lat_req[%0d]: got %b want 1", k, mem_req); end
      checks++; if (mem_addr !== 32'(4 * ((k - 1) / 4))) begin errors++; $display("FAIL lat_addr[%0d]: got %h want %h", k, mem_addr, 32'(4 * ((k - 1) / 4))); end
      checks++; if (valid !== exp_valid) begin errors++; $display("FAIL lat_valid[%0d]: got %b want %b", k, valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (instr !== 32'h2000_0000 + 32'(4 * ((k - 5) / 4))) begin errors++; $display("FAIL lat_instr[%0d]: got %h want %h", k, instr, 32'h2000_0000 + 32'(4 * ((k - 5) / 4))); end
      end
    end
  endtask

  task automatic test_redirect_drop();
    int n;
    do_reset(3);
    repeat (10) step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h08) begin errors++; $display("FAIL drop_inflight: got req=%b addr=%h want req=1 addr=00000008", mem_req, mem_addr); end
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h08) begin errors++; $display("FAIL drop_hold: got req=%b addr=%h want req=1 addr=00000008", mem_req, mem_addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL drop_flush: got %b want 0", valid); end
    step();
    checks++; if (mem_addr !== 32'h08) begin errors++; $display("FAIL drop_hold2: got %h want 00000008", mem_addr); end
    step();
    checks++; if (mem_req !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL drop_idle: got req=%b valid=%b want req=0 valid=0", mem_req, valid); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL drop_target_addr: got req=%b addr=%h want req=1 addr=00000100", mem_req, mem_addr); end
    n = 0;
    while (n < 10 && valid !== 1'b1) begin
      step();
      n++;
    end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL drop_timeout: got valid=%b want 1 within 10 cycles", valid); end
    checks++; if (n !== 4) begin errors++; $display("FAIL drop_latency: got %0d cycles want 4", n); end
    checks++; if (instr !== 32'h2000_0100) begin errors++; $display("FAIL drop_instr: got %h want 20000100", instr); end
    checks++; if (pc_plus4 !== 32'h104) begin errors++; $display("FAIL drop_pc4: got %h want 00000104", pc_plus4); end
  endtask

  task automatic test_redirect_pop_ack();
    do_reset(0);
    repeat (3) step();
    checks++; if (valid !== 1'b1 || instr !== 32'h2000_0004 || mem_ack !== 1'b1) begin errors++; $display("FAIL rpa_setup: got valid=%b instr=%h ack=%b want 1 20000004 1", valid, instr, mem_ack); end
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    checks++; if (valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rpa_flush: got valid=%b req=%b want 0 0", valid, mem_req); end
    step();
    checks++; if (valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL rpa_target_req: got valid=%b req=%b addr=%h want 0 1 00000200", valid, mem_req, mem_addr); end
    step();
    checks++; if (valid !== 1'b1 || instr !== 32'h2000_0200 || pc_plus4 !== 32'h204) begin errors++; $display("FAIL rpa_first: got valid=%b instr=%h pc4=%h want 1 20000200 00000204", valid, instr, pc_plus4); end
  endtask

  task automatic test_reset_mid();
    do_reset(0);
    stall = 1'b1;
    repeat (3) step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h08 || instr !== 32'h2000_0000) begin errors++; $display("FAIL rm_setup: got req=%b addr=%h instr=%h want 1 00000008 20000000", mem_req, mem_addr, instr); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rm_async_req: got req=%b addr=%h want 0 00000000", mem_req, mem_addr); end
    checks++; if (valid !== 1'b0 || instr !== 32'h0 || pc_plus4 !== 32'h0) begin errors++; $display("FAIL rm_async_out: got valid=%b instr=%h pc4=%h want 0 0 0", valid, instr, pc_plus4); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall = 1'b0;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL rm_restart_addr: got req=%b addr=%h want 1 00000000", mem_req, mem_addr); end
    step();
    checks++; if (valid !== 1'b1 || instr !== 32'h2000_0000 || pc_plus4 !== 32'h4) begin errors++; $display("FAIL rm_restart_data: got valid=%b instr=%h pc4=%h want 1 20000000 00000004", valid, instr, pc_plus4); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_latency();
    test_redirect_drop();
    test_redirect_pop_ack();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front-end for the 5-stage pipelined CPU. It owns the fetch PC and runs a single-outstanding req/ack handshake to a variable-latency instruction memory. Returned instructions and their PC+4 are buffered in a small FIFO that feeds the IF/ID pipeline register. A taken branch from the MEM stage (PCSrc) redirects fetch, flushes the queue and discards any in-flight response.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset

- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- mem_req_o  out  1  instruction memory request
- mem_addr_o  out  32  word address of the request; held stable while mem_req_o=1 and mem_ack_i=0
- mem_ack_i  in  1  response valid this cycle; only meaningful when mem_req_o=1
- mem_data_i  in  32  instruction word; sampled when mem_req_o & mem_ack_i
- redirect_i  in  1  taken branch (PCSrc) from the MEM stage
- redirect_pc_i  in  32  branch target
- stall_i  in  1  IF/ID not writable (hazard unit); blocks the pop
- valid_o  out  1  head entry valid
- instr_o  out  32  head instruction; 0 when valid_o=0
- pc_plus4_o  out  32  head PC+4; 0 when valid_o=0

## Operation
- One clock (clk_i); rst_i is asynchronous and active-high.
- Registers: fetch_pc (32), state {IDLE, WAIT, DROP}, FIFO of DEPTH × {instr, pc+4}, count (clog2(DEPTH)+1 bits), rd/wr pointers that wrap modulo DEPTH.
- pop = valid_o & ~stall_i & ~redirect_i. push = (state==WAIT) & mem_ack_i & ~redirect_i.
- space = (count − pop + push) < DEPTH, evaluated on next-cycle occupancy.
- mem_req_o = (state==WAIT) | (state==DROP). mem_addr_o = registered request address.
- IDLE:
  - redirect_i: fetch_pc←redirect_pc_i; stay IDLE.
  - else if space: mem_addr_o←fetch_pc; →WAIT.
- WAIT:
  - ack & redirect_i: discard data; fetch_pc←redirect_pc_i; →IDLE.
  - ack, no redirect: push; fetch_pc←fetch_pc+4. If space, mem_addr_o←fetch_pc+4 and stay WAIT (back-to-back). Otherwise →IDLE.
  - no ack & redirect_i: fetch_pc←redirect_pc_i; →DROP. Address stays unchanged until the ack.
  - no ack, no redirect: hold.
- DROP:
  - ack: discard data; →IDLE.
  - redirect_i: updates fetch_pc; the latest redirect wins.
- Redirect in any state: count←0, rd/wr pointers←0. The redirect wins over a simultaneous pop or push.
- Because only one request is ever outstanding and issue requires space, push never occurs when full. Pop never occurs when empty.
- PC arithmetic is 32-bit, wraps modulo 2^32, with no alignment check.

## Timing
- Reset values: state IDLE, fetch_pc=RESET_PC, count 0, mem_req_o 0, mem_addr_o RESET_PC, valid_o 0, instr_o 0, pc_plus4_o 0. Reset asserted mid-request aborts it immediately; a late ack is ignored because mem_req_o=0.
- First request: mem_req_o rises in the first cycle after rst_i deasserts plus one (IDLE→WAIT).
- Push at the edge ending the ack cycle; valid_o is 1 the following cycle.
- Zero-wait memory (ack same cycle as req): throughput is 1 instruction per cycle while not stalled.
- Redirect asserted in cycle t, with zero-wait memory:
  - fetch_pc updated at t+1.
  - Request for the target in t+2.
  - valid_o with the target instruction in t+3.
  - valid_o is 0 in t+1 and t+2.
- Redirect→first-valid latency with an N-cycle-wait memory: 3+N cycles, plus the remaining DROP time if a request was in flight.
- Outputs instr_o, pc_plus4_o and valid_o are combinational from FIFO head and count (no register stage).

## Test plan
- Reset, zero-wait memory returning 0x2000_0000|addr, stall_i=0 → valid_o from cycle 3; instr_o sequence 0x2000_0000, 0x2000_0004, …; pc_plus4_o 4, 8, …; one per cycle.
- stall_i held high for 10 cycles → exactly DEPTH=4 entries buffered, then mem_req_o=0. Release stall → 4 pops in 4 consecutive cycles, in order, then fetch resumes at 0x10.
- Memory with 3-cycle ack latency → mem_addr_o constant during each wait; one push per 4 cycles; no duplicate or skipped addresses.
- redirect_i with redirect_pc_i=0x100 while a 3-cycle request to 0x08 is in flight → DROP; the response for 0x08 is never output; the next mem_addr_o is 0x100; the next valid instr_o is from 0x100 with pc_plus4_o=0x104.
- redirect_i in the same cycle as a pop (stall_i=0) and an ack → queue empty next cycle (valid_o=0), pushed data dropped, fetch_pc=target.
- rst_i pulsed mid-WAIT with 2 entries queued → all outputs return to reset values asynchronously; fetch restarts at RESET_PC.
